// File: rtl/bcd_updown_counter.sv
// Multi-digit synchronous BCD up/down counter with parallel load, load validity flag and terminal count.
// Optional build macro BCD_CNT_SATURATE_EN: saturate at all-9s / all-0s instead of wrapping.
module bcd_updown_counter #(
   parameter int unsigned DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  tc,
   output logic                  load_err
);

   localparam int unsigned W = 4 * DIGITS;

   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("bcd_updown_counter: DIGITS must be in 1..8");
   end

   logic [W-1:0] cnt_q, cnt_d;
   logic         tc_q, tc_d;
   logic         load_err_q, load_err_d;

   logic [W-1:0] step_val;
   logic         at_limit;
   logic         load_ok;

   // Ripple carry/borrow across digits; at_limit is the carry out of the top digit.
   always_comb begin
      logic       carry;
      logic [3:0] dig;
      step_val = cnt_q;
      carry    = 1'b1;
      dig      = 4'd0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         dig = cnt_q[4*k +: 4];
         if (carry) begin
            if (up) begin
               step_val[4*k +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
            end else begin
               step_val[4*k +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
            end
         end
         carry = carry & (up ? (dig == 4'd9) : (dig == 4'd0));
      end
      at_limit = carry;
   end

   // Load value is accepted only when every nibble is a decimal digit.
   always_comb begin
      load_ok = 1'b1;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (load_val[4*k +: 4] > 4'd9) begin
            load_ok = 1'b0;
         end
      end
   end

   always_comb begin
      cnt_d      = cnt_q;
      tc_d       = 1'b0;
      load_err_d = 1'b0;
      if (load) begin
         if (load_ok) begin
            cnt_d = load_val;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (en) begin
         if (at_limit) begin
            tc_d = 1'b1;
`ifdef BCD_CNT_SATURATE_EN
            cnt_d = cnt_q;
`else
            cnt_d = step_val;
`endif
         end else begin
            cnt_d = step_val;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q      <= '0;
         tc_q       <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         tc_q       <= tc_d;
         load_err_q <= load_err_d;
      end
   end

   assign bcd_out  = cnt_q;
   assign tc       = tc_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench for bcd_updown_counter (DIGITS = 2); honours BCD_CNT_SATURATE_EN.
module tb_bcd_updown_counter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       up;
   logic       load;
   logic [7:0] load_val;
   logic [7:0] bcd_out;
   logic       tc;
   logic       load_err;

   int tests;
   int errors;

   bcd_updown_counter #(.DIGITS(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .bcd_out  (bcd_out),
      .tc       (tc),
      .load_err (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [7:0] v);
      load = 1'b1; load_val = v; en = 1'b0;
      tick();
      load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 8'h55;
      tick(); tick();
      tests++; if (bcd_out !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %h want 00", bcd_out); end
      tests++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc: got %b want 0", tc); end
      tests++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_lerr: got %b want 0", load_err); end
      rst = 1'b1; load = 1'b0; en = 1'b0;
   endtask

   task automatic test_up_wrap();
      logic [7:0] exp_v [3];
      logic       exp_t [3];
      exp_v[0] = 8'h98; exp_t[0] = 1'b0;
      exp_v[1] = 8'h99; exp_t[1] = 1'b0;
`ifdef BCD_CNT_SATURATE_EN
      exp_v[2] = 8'h99; exp_t[2] = 1'b1;
`else
      exp_v[2] = 8'h00; exp_t[2] = 1'b1;
`endif
      do_load(8'h97);
      tests++; if (bcd_out !== 8'h97) begin errors++; $display("FAIL up_load: got %h want 97", bcd_out); end
      en = 1'b1; up = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if (bcd_out !== exp_v[i] || tc !== exp_t[i]) begin
            errors++; $display("FAIL up_wrap_%0d: got %h tc=%b want %h tc=%b", i, bcd_out, tc, exp_v[i], exp_t[i]);
         end
      end
      en = 1'b0;
      tick();
      tests++; if (tc !== 1'b0) begin errors++; $display("FAIL up_tc_clear: got %b want 0", tc); end
   endtask

   task automatic test_down_borrow();
      do_load(8'h10);
      en = 1'b1; up = 1'b0;
      tick();
      tests++; if (bcd_out !== 8'h09 || tc !== 1'b0) begin errors++; $display("FAIL down_borrow: got %h tc=%b want 09 tc=0", bcd_out, tc); end
      tick();
      tests++; if (bcd_out !== 8'h08) begin errors++; $display("FAIL down_step: got %h want 08", bcd_out); end
      do_load(8'h00);
      en = 1'b1; up = 1'b0;
      tick();
`ifdef BCD_CNT_SATURATE_EN
      tests++; if (bcd_out !== 8'h00 || tc !== 1'b1) begin errors++; $display("FAIL down_wrap: got %h tc=%b want 00 tc=1", bcd_out, tc); end
`else
      tests++; if (bcd_out !== 8'h99 || tc !== 1'b1) begin errors++; $display("FAIL down_wrap: got %h tc=%b want 99 tc=1", bcd_out, tc); end
`endif
      en = 1'b0;
   endtask

   task automatic test_invalid_load();
      do_load(8'h42);
      load = 1'b1; load_val = 8'h3A; en = 1'b1; up = 1'b1;
      tick();
      tests++; if (bcd_out !== 8'h42 || load_err !== 1'b1 || tc !== 1'b0) begin
         errors++; $display("FAIL invalid_load: got %h lerr=%b tc=%b want 42 lerr=1 tc=0", bcd_out, load_err, tc);
      end
      load = 1'b0;
      tick();
      tests++; if (bcd_out !== 8'h43 || load_err !== 1'b0) begin
         errors++; $display("FAIL invalid_resume: got %h lerr=%b want 43 lerr=0", bcd_out, load_err);
      end
      load = 1'b1; load_val = 8'hF0; en = 1'b0;
      tick();
      tests++; if (bcd_out !== 8'h43 || load_err !== 1'b1) begin
         errors++; $display("FAIL invalid_hi_nibble: got %h lerr=%b want 43 lerr=1", bcd_out, load_err);
      end
      load = 1'b0; en = 1'b0;
   endtask

   task automatic test_priority();
      load = 1'b1; load_val = 8'h55; en = 1'b1; up = 1'b1;
      tick();
      tests++; if (bcd_out !== 8'h55) begin errors++; $display("FAIL prio_load_en: got %h want 55", bcd_out); end
      rst = 1'b0; load_val = 8'h77;
      tick();
      tests++; if (bcd_out !== 8'h00) begin errors++; $display("FAIL prio_rst_load: got %h want 00", bcd_out); end
      rst = 1'b1; load = 1'b0; en = 1'b1;
      tick();
      tests++; if (bcd_out !== 8'h01) begin errors++; $display("FAIL prio_after_rst: got %h want 01", bcd_out); end
      en = 1'b0;
   endtask

   task automatic test_reverse_and_hold();
      do_load(8'h19);
      en = 1'b1; up = 1'b1;
      tick();
      tests++; if (bcd_out !== 8'h20) begin errors++; $display("FAIL rev_carry: got %h want 20", bcd_out); end
      up = 1'b0;
      tick();
      tests++; if (bcd_out !== 8'h19) begin errors++; $display("FAIL rev_back: got %h want 19", bcd_out); end
      tick();
      tests++; if (bcd_out !== 8'h18) begin errors++; $display("FAIL rev_down: got %h want 18", bcd_out); end
      en = 1'b0;
      tick(); tick();
      tests++; if (bcd_out !== 8'h18 || tc !== 1'b0 || load_err !== 1'b0) begin
         errors++; $display("FAIL hold: got %h tc=%b lerr=%b want 18 0 0", bcd_out, tc, load_err);
      end
   endtask

   task automatic test_saturate();
`ifdef BCD_CNT_SATURATE_EN
      do_load(8'h99);
      en = 1'b1; up = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if (bcd_out !== 8'h99 || tc !== 1'b1) begin
            errors++; $display("FAIL sat_hold_%0d: got %h tc=%b want 99 tc=1", i, bcd_out, tc);
         end
      end
      up = 1'b0;
      tick();
      tests++; if (bcd_out !== 8'h98 || tc !== 1'b0) begin errors++; $display("FAIL sat_leave: got %h tc=%b want 98 tc=0", bcd_out, tc); end
      en = 1'b0;
`else
      do_load(8'h99);
      en = 1'b1; up = 1'b1;
      tick(); tick();
      tests++; if (bcd_out !== 8'h01 || tc !== 1'b0) begin errors++; $display("FAIL wrap_continue: got %h tc=%b want 01 tc=0", bcd_out, tc); end
      en = 1'b0;
`endif
   endtask

   initial begin
      tests = 0; errors = 0;
      rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
      test_reset();
      test_up_wrap();
      test_down_borrow();
      test_invalid_load();
      test_priority();
      test_reverse_and_hold();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit synchronous BCD counter, the next generation of the team's 4-bit BCD synchronous counter. Counts up or down across `DIGITS` cascaded decimal digits with count enable, synchronous parallel load with BCD validity checking, and a registered terminal-count flag. Intended as the timebase and event-count block in display, timer and frequency-meter designs, driving seven-segment decoders directly from `bcd_out`.

## Interface
- `DIGITS`, default 2: number of BCD digits; legal range 1..8; total count width is 4*DIGITS.
- `clk`  input  1  sole clock; all state changes on rising edge.
- `rst`  input  1  synchronous reset, active-low; sampled on rising `clk`.
- `en`  input  1  count enable; one step per rising edge while high.
- `up`  input  1  direction: 1 = increment, 0 = decrement.
- `load`  input  1  synchronous parallel load request.
- `load_val`  input  4*DIGITS  value to load; digit 0 (least significant) in bits [3:0].
- `bcd_out`  output  4*DIGITS  registered count; digit k in bits [4k+3:4k].
- `tc`  output  1  registered terminal-count flag.
- `load_err`  output  1  registered flag: last load request carried a non-BCD nibble.

## Operation
- Priority per edge: `rst` low > `load` > `en` > hold.
- Reset (`rst` = 0 at edge): `bcd_out` = 0, `tc` = 0, `load_err` = 0; all other inputs ignored.
- Load, valid (every nibble of `load_val` ≤ 9): `bcd_out` <= `load_val`; `tc` = 0, `load_err` = 0; `en` ignored that cycle.
- Load, invalid (any nibble 10..15): `bcd_out` holds, `load_err` = 1, `tc` = 0; no count that cycle even if `en` = 1.
- Count up: digit 0 steps 0→…→9→0; digit k steps when all digits below k equal 9; a digit at 9 that steps becomes 0.
- Count down: digit 0 steps 9→…→0→9; digit k steps when all digits below k equal 0; a digit at 0 that steps becomes 9.
- Wrap: all-9s counting up becomes all-0s; all-0s counting down becomes all-9s; the edge that wraps sets `tc` = 1.
- `tc` and `load_err` are single-cycle: each clears on the next edge unless re-asserted by that edge's operation.
- Hold (`en` = 0, no load): `bcd_out` holds; `tc` = 0, `load_err` = 0.
- Every nibble of `bcd_out` is always 0..9; no non-BCD state reachable.

## Timing
- Latency: one edge; `bcd_out`, `tc`, `load_err` reflect the operation sampled at edge n during cycle n..n+1.
- All outputs registered; no combinational input-to-output path.
- `up` change takes effect on the next enabled edge; reversing at a digit boundary does not skip or repeat a value.
- Reset mid-count or concurrent with `load`/`en`: reset wins; state is 0 after that edge.
- Deassertion of `rst`: first count/load acts on the first edge with `rst` = 1.
- Carry chain is combinational across all digits within one cycle; DIGITS = 8 must close timing at the project's standard clock.

## Configuration
- Macro `BCD_CNT_SATURATE_EN`.
- Defined: counter saturates instead of wrapping. Up at all-9s and down at all-0s hold the value; `tc` = 1 for every enabled edge attempted at the limit. Stepping away from the limit is normal.
- Undefined (default): wrap behaviour as in Operation.

## Test plan
- Reset: DIGITS = 2, drive `rst` = 0 for 2 edges with `en` = 1, `load` = 1 -> `bcd_out` = 0x00, `tc` = 0, `load_err` = 0.
- Up wrap: load 0x97, `en` = 1, `up` = 1 for 3 edges -> 0x98, 0x99, 0x00 with `tc` = 1 only in the cycle showing 0x00.
- Down borrow and wrap: load 0x10, `up` = 0, 2 edges -> 0x09, 0x08; load 0x00, 1 edge -> 0x99 with `tc` = 1.
- Invalid load: load 0x3A while count = 0x42 and `en` = 1 -> `bcd_out` stays 0x42, `load_err` = 1 for one cycle, then counting resumes at 0x43.
- Priority: `load` = 1 (0x55) with `en` = 1 -> 0x55, no increment; `rst` = 0 with `load` = 1 -> 0x00.
- Saturate build (`BCD_CNT_SATURATE_EN` defined): load 0x99, `up` = 1, 3 edges -> holds 0x99, `tc` = 1 each edge; `up` = 0 -> 0x98, `tc` = 0.
